// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multicycle RV32I control unit
package mc_pkg;

  // FSM state encodings; 12-15 are unused and recover to FETCH
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_instrdec.sv
// rtl/mc_instrdec.sv - immediate-format and ALU-control decode from opcode/funct fields
module mc_instrdec
  import mc_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  aluop_e     aluop,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  // op[5] separates R-type from I-type, so addi with imm[10]=1 stays an add
  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - Moore FSM sequencing the shared multicycle RV32I datapath
module mc_controller
  import mc_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       halted,
  output logic [3:0] state_dbg
);

  logic [3:0] state;
  logic [3:0] state_next;
  aluop_e     aluop;
  logic       pc_update;
  logic       branch;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    adr_src     = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_B;
    aluop       = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ir_write_s = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        pc_update  = 1'b1;
      end
      // DECODE precomputes the branch target into ALUOut
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_A;
        aluop     = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_A;
        aluop     = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: begin
        adr_src = 1'b0;
      end
    endcase
  end

  mc_instrdec u_instrdec (
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .aluop       (aluop),
    .imm_src     (imm_src),
    .alu_control (alu_control)
  );

  // reset suppresses every architectural write on the edge it is sampled
  assign pc_write  = ~reset & (pc_update | (branch & zero));
  assign mem_write = ~reset & mem_write_s;
  assign ir_write  = ~reset & ir_write_s;
  assign reg_write = ~reset & reg_write_s;
  assign halted    = (state == S_HALT);
  assign state_dbg = state;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - instruction-level reference checks of the multicycle control unit
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, halted;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_dbg;
  logic [20:0] obs;

  int errors = 0;
  int checks = 0;
  int seq[$];

  mc_controller dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .reg_write   (reg_write),
    .halted      (halted),
    .state_dbg   (state_dbg)
  );

  assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, imm_src, alu_control, reg_write, halted, state_dbg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU operation an R/I instruction asks for, from its funct fields
  function automatic logic [2:0] funct_alu(logic [6:0] o, logic [2:0] f3, logic f7);
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    if (f3 == 3'b000 && f7 && o == 7'b0110011) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [20:0] model(logic [3:0] st, logic [6:0] o, logic [2:0] f3,
                                        logic f7, logic z, logic rst);
    logic pcw, adr, memw, irw, rw, hlt;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    {pcw, adr, memw, irw, rw, hlt} = '0;
    {res, sa, sb} = '0;
    alu = 3'b000;
    imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 :
          (o == 7'b1101111) ? 2'b11 : 2'b00;
    case (st)
      4'd0:  begin irw = 1; sb = 2'b10; res = 2'b10; pcw = 1; end
      4'd1:  begin sa = 2'b01; sb = 2'b01; end
      4'd2:  begin sa = 2'b10; sb = 2'b01; end
      4'd3:  adr = 1;
      4'd4:  begin res = 2'b01; rw = 1; end
      4'd5:  begin adr = 1; memw = 1; end
      4'd6:  begin sa = 2'b10; alu = funct_alu(o, f3, f7); end
      4'd7:  begin sa = 2'b10; sb = 2'b01; alu = funct_alu(o, f3, f7); end
      4'd8:  rw = 1;
      4'd9:  begin sa = 2'b10; alu = 3'b001; pcw = z; end
      4'd10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      4'd11: hlt = 1;
      default: hlt = 0;
    endcase
    if (rst) {pcw, irw, rw, memw} = '0;
    return {pcw, adr, memw, irw, res, sa, sb, imm, alu, rw, hlt, st};
  endfunction

  // state walk each instruction class takes, starting at FETCH
  function automatic void set_seq(logic [6:0] o);
    seq.delete();
    case (o)
      7'b0000011: seq = '{0, 1, 2, 3, 4};
      7'b0100011: seq = '{0, 1, 2, 5};
      7'b0110011: seq = '{0, 1, 6, 8};
      7'b0010011: seq = '{0, 1, 7, 8};
      7'b1100011: seq = '{0, 1, 9};
      7'b1101111: seq = '{0, 1, 10, 8};
      default:    seq = '{0, 1, 11};
    endcase
  endfunction

  task automatic check(string tag, logic [20:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_instr(logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    set_seq(o);
    foreach (seq[i]) begin
      @(negedge clk);
      check($sformatf("op%b_f3%b_s%0d", o, f3, seq[i]),
            model(4'(seq[i]), o, f3, f7, z, 1'b0));
      @(posedge clk); #1;
    end
  endtask

  logic [6:0] legal_ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                7'b0010011, 7'b1100011, 7'b1101111};

  initial begin
    reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", model(4'd0, op, funct3, funct7b5, zero, 1'b1));
      @(posedge clk); #1;
    end
    reset = 1'b0;

    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b1);
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
    run_instr(7'b0110011, 3'b010, 1'b0, 1'b0);
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b1);

    for (int n = 0; n < 60; n++) begin
      run_instr(legal_ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset landing in MEMREAD abandons the load
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check($sformatf("lw_abort_s%0d", s), model(4'(s), op, funct3, funct7b5, zero, 1'b0));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check("reset_in_memread", model(4'd3, op, funct3, funct7b5, zero, 1'b1));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("fetch_after_abort", model(4'd0, op, funct3, funct7b5, zero, 1'b0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(7'b1111111, 3'b000, 1'b0, 1'b1);
    for (int h = 0; h < 10; h++) begin
      @(negedge clk);
      check($sformatf("halt_hold_%0d", h), model(4'd11, op, funct3, funct7b5, zero, 1'b0));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check("reset_in_halt", model(4'd11, op, funct3, funct7b5, zero, 1'b1));
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Control unit for the multicycle RV32I core.
- A Moore FSM plus combinational decoders that sequence the shared datapath across 3–5 cycles per instruction.
- Shared resources: one memory for instructions and data, one ALU also used for PC+4 and branch target, and the IR/OldPC/A/B/ALUOut/Data registers.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU, beq and jal.

Parameters:
- HALT_ON_ILLEGAL, 1: 1 = an unimplemented opcode enters a sticky HALT state; 0 = it is treated as a NOP and returns to FETCH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero  in  1  ALU zero flag
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = Result
- mem_write  out  1  memory write enable
- ir_write  out  1  IR and OldPC load enable
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = A
- alu_src_b  out  2  00 = B, 01 = ImmExt, 10 = constant 4
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- reg_write  out  1  register file write enable
- halted  out  1  FSM is in HALT
- state_dbg  out  4  current state encoding

Behaviour:
- Single clock domain, clk. reset is synchronous and active-high.
- Reset:
  - reset high at a rising edge loads the state register with FETCH.
  - While reset is high, pc_write, ir_write, reg_write and mem_write are forced to 0; all other outputs decode from the current state.
  - The first cycle after reset is FETCH. halted = 0.
  - Reset asserted in any state, including HALT, aborts the instruction in progress; no write enable asserts on that edge.
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, HALT=11. Encodings 12–15 go to FETCH.
- Per-state outputs. Any unlisted enable is 0; unlisted selects are don't-care, driven as 00.
  - FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, aluop=add, result_src=10, pc_update=1.
  - DECODE: alu_src_a=01, alu_src_b=01, aluop=add (computes the branch target into ALUOut).
  - MEMADR: alu_src_a=10, alu_src_b=01, aluop=add.
  - MEMREAD: result_src=00, adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1.
  - EXECR: alu_src_a=10, alu_src_b=00, aluop=funct.
  - EXECI: alu_src_a=10, alu_src_b=01, aluop=funct.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: alu_src_a=10, alu_src_b=00, aluop=sub, result_src=00, branch=1.
  - JAL: alu_src_a=01, alu_src_b=10, aluop=add, result_src=00, pc_update=1.
  - HALT: all enables 0, halted=1.
- pc_write = pc_update | (branch & zero). This is the only output that depends on zero.
- Transitions:
  - FETCH→DECODE.
  - DECODE: lw/sw→MEMADR, R→EXECR, I-ALU→EXECI, beq→BEQ, jal→JAL, other→HALT (or FETCH if HALT_ON_ILLEGAL=0).
  - MEMADR: lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECR/EXECI→ALUWB→FETCH.
  - BEQ→FETCH.
  - JAL→ALUWB.
  - HALT→HALT.
- Cycles per instruction: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- op/funct inputs are valid from DECODE onward; the FSM ignores them in FETCH.
- imm_src is combinational from op: lw/I-ALU 00, sw 01, beq 10, jal 11, else 00.
- alu_control:
  - aluop add → 000; aluop sub → 001.
  - aluop funct decodes funct3:
    - 000: sub if funct7b5 & op[5], else add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.
    - other → 000.
- No X on any output in any state.

Decomposition:
- Package mc_pkg holds:
  - the state enum (4-bit);
  - opcode constants (lw, sw, R, I-ALU, beq, jal);
  - the aluop enum (add, sub, funct);
  - alu_control codes;
  - named select constants for result_src, alu_src_a, alu_src_b and imm_src.
- Sub-module mc_instrdec handles the imm_src decode and the aluop+funct→alu_control decode.
- FSM state register and next-state/output logic stay in mc_controller.

Test Plan:
- Reset held 3 cycles, then released → state_dbg=0, ir_write=1, pc_write=1, alu_src_b=10 in the first cycle; all enables 0 while reset=1.
- op=0000011 (lw) → state sequence 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01; imm_src=00.
- op=0100011 (sw) → sequence 0,1,2,5,0; mem_write=1 only in state 5 with adr_src=1; imm_src=01.
- op=0110011, funct3=000, funct7b5=1 → alu_control=001 in EXECR, then ALUWB; funct3=010 → 101.
- op=1100011 (beq) with zero=1 → pc_write=1 in BEQ; with zero=0 → pc_write=0; both return to FETCH after 3 cycles.
- op=1111111 → halted=1 and stays there for 10 cycles with no enables. reset then gives FETCH. Assert reset in MEMREAD → next state FETCH with no reg_write.
